// File: rtl/data_buffer_write_pkg.sv
// Shared types and constants for the write-direction data buffer.
// Optional parity support is selected with DATA_BUFFER_WRITE_PARITY_EN.
package data_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Strobes (WR/RD/CS) are active low, so an idle bus reads as 1.
  localparam logic BUS_IDLE_STROBE = 1'b1;

  localparam int DEPTH_DEFAULT       = 4;
  localparam int SYNC_STAGES_DEFAULT = 2;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 2;
  localparam int ENTRY_W = DATA_W + ADDR_W;

`ifdef DATA_BUFFER_WRITE_PARITY_EN
  // Shadow carries the parity bit until the commit-time check.
  localparam int SHADOW_W = ENTRY_W + 1;
`else
  localparam int SHADOW_W = ENTRY_W;
`endif

  // Odd parity: data plus parity bit must contain an odd number of ones.
  function automatic logic parity_ok(input logic [DATA_W-1:0] d, input logic dp);
    return ^{d, dp};
  endfunction

endpackage

// File: rtl/data_buffer_write_if.sv
// Host bus and consumer-side signals of the write data buffer.
// DP and Par_err exist only when DATA_BUFFER_WRITE_PARITY_EN is defined.
interface data_buffer_write_if;

  logic       WR;
  logic       RD;
  logic       CS;
  logic [7:0] D;
  logic [1:0] A;
`ifdef DATA_BUFFER_WRITE_PARITY_EN
  logic       DP;
  logic       Par_err;
`endif
  logic [7:0] Wr_data;
  logic [1:0] Wr_addr;
  logic       Wr_valid;
  logic       Wr_ready;
  logic       Fifo_full;
  logic       Overflow;
  logic       Bus_err;
  logic       Err_clr;

  // Host plus register-logic side (drives strobes, bus and drain handshake).
  modport master (
`ifdef DATA_BUFFER_WRITE_PARITY_EN
    output DP,
    input  Par_err,
`endif
    output WR, RD, CS, D, A, Wr_ready, Err_clr,
    input  Wr_data, Wr_addr, Wr_valid, Fifo_full, Overflow, Bus_err
  );

  // Buffer side.
  modport slave (
`ifdef DATA_BUFFER_WRITE_PARITY_EN
    input  DP,
    output Par_err,
`endif
    input  WR, RD, CS, D, A, Wr_ready, Err_clr,
    output Wr_data, Wr_addr, Wr_valid, Fifo_full, Overflow, Bus_err
  );

endinterface

// File: rtl/data_buffer_write_fifo.sv
// Synchronous FIFO for committed bus writes. Head data is read straight
// from storage so it stays stable while the consumer stalls.
module data_buffer_write_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             pop_ok;
  logic             push_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign rdata = mem_q[rd_ptr_q[PTR_W-1:0]];

  // A pop frees a slot in the same cycle, so push while full succeeds if popping.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;

  // Next-state for storage and pointers.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/data_buffer_write.sv
// Write-direction data buffer: synchronizes the async host strobes and bus,
// captures each completed chip-selected write and queues {A, D} in a FIFO.
// Define DATA_BUFFER_WRITE_PARITY_EN to add the DP input and Par_err flag.
//
// state  | meaning
// IDLE   | waiting for CS low with WR low
// ARMED  | WR held low, shadowing D/A every cycle
// COMMIT | WR has risen, push the shadow into the FIFO
module data_buffer_write
  import data_buffer_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic                CLK,
  input  logic                RESET_N,
  data_buffer_write_if.slave  bus
);

  // Strobes in the top three bits, then the shadowed payload.
  localparam int BUS_W = SHADOW_W + 3;
  localparam logic [BUS_W-1:0] SYNC_RST = {{3{BUS_IDLE_STROBE}}, {SHADOW_W{1'b0}}};

  logic [BUS_W-1:0]    bus_raw;
  logic [BUS_W-1:0]    sync_q [SYNC_STAGES];
  logic [BUS_W-1:0]    sync_d [SYNC_STAGES];
  logic                wr_s, rd_s, cs_s;
  logic [SHADOW_W-1:0] data_s;

  state_e              state_q, state_d;
  logic [SHADOW_W-1:0] shadow_q, shadow_d;
  logic                push;
  logic                bus_err_set;
  logic                overflow_q, overflow_d;
  logic                bus_err_q, bus_err_d;

  logic                fifo_pop;
  logic [ENTRY_W-1:0]  fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_drop;

`ifdef DATA_BUFFER_WRITE_PARITY_EN
  logic                par_err_set;
  logic                par_err_q, par_err_d;
  assign bus_raw = {bus.WR, bus.RD, bus.CS, bus.DP, bus.A, bus.D};
`else
  assign bus_raw = {bus.WR, bus.RD, bus.CS, bus.A, bus.D};
`endif

  // Shift chain: strobes and payload travel together so they stay aligned.
  always_comb begin
    sync_d[0] = bus_raw;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  // Synchronizer flops, preset to the idle bus.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

  assign wr_s   = sync_q[SYNC_STAGES-1][BUS_W-1];
  assign rd_s   = sync_q[SYNC_STAGES-1][BUS_W-2];
  assign cs_s   = sync_q[SYNC_STAGES-1][BUS_W-3];
  assign data_s = sync_q[SYNC_STAGES-1][SHADOW_W-1:0];

  // FSM next state, shadow capture and commit push.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    push        = 1'b0;
    bus_err_set = 1'b0;
`ifdef DATA_BUFFER_WRITE_PARITY_EN
    par_err_set = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!cs_s && !wr_s) begin
          if (!rd_s) begin
            bus_err_set = 1'b1;
          end else begin
            state_d  = ST_ARMED;
            shadow_d = data_s;
          end
        end
      end
      ST_ARMED: begin
        // CS checked first so WR and CS rising together is an abort.
        if (cs_s) begin
          state_d = ST_IDLE;
        end else if (!rd_s) begin
          state_d     = ST_IDLE;
          bus_err_set = 1'b1;
        end else if (wr_s) begin
          state_d = ST_COMMIT;
        end else begin
          // Only sample while WR is low; the bus may change after WR rises.
          shadow_d = data_s;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
`ifdef DATA_BUFFER_WRITE_PARITY_EN
        if (parity_ok(shadow_q[DATA_W-1:0], shadow_q[SHADOW_W-1])) begin
          push = 1'b1;
        end else begin
          par_err_set = 1'b1;
        end
`else
        push = 1'b1;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky error flags; a set in the same cycle as a clear wins.
  always_comb begin
    overflow_d = (overflow_q & ~bus.Err_clr) | fifo_drop;
    bus_err_d  = (bus_err_q  & ~bus.Err_clr) | bus_err_set;
`ifdef DATA_BUFFER_WRITE_PARITY_EN
    par_err_d  = (par_err_q  & ~bus.Err_clr) | par_err_set;
`endif
  end

  // FSM, shadow and flag registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      shadow_q   <= '0;
      overflow_q <= 1'b0;
      bus_err_q  <= 1'b0;
`ifdef DATA_BUFFER_WRITE_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      overflow_q <= overflow_d;
      bus_err_q  <= bus_err_d;
`ifdef DATA_BUFFER_WRITE_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  assign fifo_pop = ~fifo_empty & bus.Wr_ready;

  data_buffer_write_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .push  (push),
    .pop   (fifo_pop),
    .wdata (shadow_q[ENTRY_W-1:0]),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign bus.Wr_data   = fifo_head[DATA_W-1:0];
  assign bus.Wr_addr   = fifo_head[ENTRY_W-1:DATA_W];
  assign bus.Wr_valid  = ~fifo_empty;
  assign bus.Fifo_full = fifo_full;
  assign bus.Overflow  = overflow_q;
  assign bus.Bus_err   = bus_err_q;
`ifdef DATA_BUFFER_WRITE_PARITY_EN
  assign bus.Par_err   = par_err_q;
`endif

endmodule
